// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter with bounded bursts sharing one syncfifo write port.
// Define WR_ARB_STATS_EN to add the stall_cnt_o full-stall statistics counter.
module fifo_wr_arb #(
  parameter int N         = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N-1:0]       req_i,
  input  logic [N*WIDTH-1:0] data_i,
  output logic [N-1:0]       gnt_o,
  input  logic               fifo_full_i,
  output logic               fifo_wr_en_o,
  output logic [WIDTH-1:0]   fifo_wr_data_o
`ifdef WR_ARB_STATS_EN
  ,
  output logic [15:0]        stall_cnt_o
`endif
);

  localparam int PW = $clog2(N);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, OWN} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [PW-1:0]  ownerIdx_q, ownerIdx_d;
  logic [PW-1:0]  rrPtr_q, rrPtr_d;
  logic [CW-1:0]  burstCnt_q, burstCnt_d;
  logic [PW-1:0]  pickIdx;
  logic           ownerReq;
  logic           anyReq;
  logic           accept;
  logic           releaseNow;
  logic           grantNew;

  // Scanning downward lets the lowest offset from ptr overwrite later ones.
  function automatic logic [PW-1:0] rrPick(input logic [N-1:0] req, input logic [PW-1:0] ptr);
    logic [PW-1:0] sel;
    int            cand;
    sel = ptr;
    for (int i = N - 1; i >= 0; i--) begin
      cand = (int'(ptr) + i) % N;
      if (req[cand]) sel = PW'(cand);
    end
    return sel;
  endfunction

  assign ownerReq     = |(gnt_q & req_i);
  assign anyReq       = |req_i;
  assign pickIdx      = rrPick(req_i, rrPtr_q);
  assign accept       = (state_q == OWN) && ownerReq && !fifo_full_i && !rst_i;
  assign releaseNow   = !ownerReq || (accept && (burstCnt_q == CW'(MAX_BURST - 1)));
  assign fifo_wr_en_o = accept;
  assign gnt_o        = gnt_q;

  always_comb begin
    fifo_wr_data_o = '0;
    if (state_q == OWN) fifo_wr_data_o = data_i[ownerIdx_q*WIDTH +: WIDTH];
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ownerIdx_d = ownerIdx_q;
    rrPtr_d    = rrPtr_q;
    burstCnt_d = burstCnt_q;
    grantNew   = 1'b0;
    case (state_q)
      IDLE: begin
        if (anyReq) grantNew = 1'b1;
      end
      OWN: begin
        if (accept) burstCnt_d = burstCnt_q + CW'(1);
        // The owner is last in search order, so it is re-picked only when alone.
        if (releaseNow) begin
          if (anyReq) begin
            grantNew = 1'b1;
          end else begin
            state_d    = IDLE;
            gnt_d      = '0;
            burstCnt_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    if (grantNew) begin
      state_d    = OWN;
      gnt_d      = '0;
      gnt_d[pickIdx] = 1'b1;
      ownerIdx_d = pickIdx;
      rrPtr_d    = (pickIdx == PW'(N - 1)) ? '0 : pickIdx + PW'(1);
      burstCnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      ownerIdx_q <= '0;
      rrPtr_q    <= '0;
      burstCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ownerIdx_q <= ownerIdx_d;
      rrPtr_q    <= rrPtr_d;
      burstCnt_q <= burstCnt_d;
    end
  end

`ifdef WR_ARB_STATS_EN
  logic [15:0] stallCnt_q;

  // Counts cycles where the owner is blocked only by a full FIFO; saturates.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stallCnt_q <= '0;
    end else if ((state_q == OWN) && ownerReq && fifo_full_i && (stallCnt_q != 16'hFFFF)) begin
      stallCnt_q <= stallCnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stallCnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed self-checking bench for fifo_wr_arb with a small syncfifo occupancy model.
// Stall-counter checks are compiled in when WR_ARB_STATS_EN is defined.
module tb_fifo_wr_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  gnt;
  logic        fifoFull;
  logic        wrEn;
  logic [7:0]  wrData;
`ifdef WR_ARB_STATS_EN
  logic [15:0] stallCnt;
`endif

  logic        rdEn;
  logic        fillFifo;
  int          fifoCount;
  int          writeWhileFull;
  logic [7:0]  wrLog[$];
  int          logBase;
  int          checks;
  int          errors;

  fifo_wr_arb #(.N(4), .WIDTH(8), .MAX_BURST(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_i          (req),
    .data_i         (data),
    .gnt_o          (gnt),
    .fifo_full_i    (fifoFull),
    .fifo_wr_en_o   (wrEn),
    .fifo_wr_data_o (wrData)
`ifdef WR_ARB_STATS_EN
    ,
    .stall_cnt_o    (stallCnt)
`endif
  );

  always #5 clk = ~clk;

  assign fifoFull = (fifoCount >= 16);

  // Depth-16 FIFO model: full reflects the registered occupancy, as syncfifo full_o does.
  always @(posedge clk) begin
    if (fillFifo) fifoCount = 16;
    if (wrEn) begin
      if (fifoCount >= 16) writeWhileFull++;
      else fifoCount++;
      wrLog.push_back(wrData);
    end
    if (rdEn && fifoCount > 0) fifoCount--;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d);
    req  = r;
    data = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; req = '0; data = '0;
    rdEn = 1'b1; fillFifo = 1'b0; fifoCount = 0; writeWhileFull = 0;
    checks = 0; errors = 0; logBase = 0;

    $display("[TB] reset behaviour");
    tick(); tick();
    checkOutput("rst_gnt", 32'(gnt), 32'h0);
    checkOutput("rst_wren", 32'(wrEn), 32'h0);
    checkOutput("idle_data", 32'(wrData), 32'h0);
    applyStimulus(4'b1111, 32'h44332211);
    checkOutput("rst_wren_with_req", 32'(wrEn), 32'h0);
    tick();
    checkOutput("rst_gnt_with_req", 32'(gnt), 32'h0);
    rst = 1'b0;
    applyStimulus(4'b0000, 32'h0);
    tick();

    $display("[TB] single requester with burst re-grant");
    logBase = wrLog.size();
    applyStimulus(4'b0001, 32'h000000A1);
    checkOutput("t1_req_cycle_wren", 32'(wrEn), 32'h0);
    tick();
    checkOutput("t1_gnt", 32'(gnt), 32'h1);
    for (int b = 1; b <= 6; b++) begin
      applyStimulus(4'b0001, 32'hA0 + 32'(b));
      checkOutput("t1_gnt_hold", 32'(gnt), 32'h1);
      checkOutput("t1_wren", 32'(wrEn), 32'h1);
      checkOutput("t1_data", 32'(wrData), 32'hA0 + 32'(b));
      tick();
    end
    applyStimulus(4'b0000, 32'h0);
    checkOutput("t1_drop_wren", 32'(wrEn), 32'h0);
    tick();
    checkOutput("t1_idle_gnt", 32'(gnt), 32'h0);
    checkOutput("t1_log_len", 32'(wrLog.size() - logBase), 32'd6);
    for (int b = 0; b < 6; b++) begin
      if (logBase + b < wrLog.size())
        checkOutput("t1_order", 32'(wrLog[logBase + b]), 32'hA1 + 32'(b));
    end

    $display("[TB] all requesters round robin");
    resetDut();
    applyStimulus(4'b1111, 32'h44332211);
    checkOutput("t2_req_cycle_wren", 32'(wrEn), 32'h0);
    tick();
    for (int t = 0; t < 20; t++) begin
      int owner;
      owner = (t / 4) % 4;
      checkOutput("t2_gnt", 32'(gnt), 32'h1 << owner);
      checkOutput("t2_wren", 32'(wrEn), 32'h1);
      checkOutput("t2_data", 32'(wrData), 32'h11 * 32'(owner + 1));
      tick();
    end
    applyStimulus(4'b0000, 32'h0);
    tick();
    checkOutput("t2_idle_gnt", 32'(gnt), 32'h0);

    $display("[TB] full stall");
    resetDut();
    rdEn = 1'b0;
    fillFifo = 1'b1;
    tick();
    fillFifo = 1'b0;
    applyStimulus(4'b0100, 32'h00C50000);
    checkOutput("t3_req_cycle_wren", 32'(wrEn), 32'h0);
    tick();
    checkOutput("t3_gnt", 32'(gnt), 32'h4);
    for (int s = 0; s < 3; s++) begin
      checkOutput("t3_gnt_held", 32'(gnt), 32'h4);
      checkOutput("t3_wren_full", 32'(wrEn), 32'h0);
      tick();
    end
    rdEn = 1'b1;
    #1;
    checkOutput("t3_wren_read_cycle", 32'(wrEn), 32'h0);
    tick();
    rdEn = 1'b0;
    #1;
    checkOutput("t3_wren_after_read", 32'(wrEn), 32'h1);
    checkOutput("t3_data", 32'(wrData), 32'hC5);
    tick();
    checkOutput("t3_wren_full_again", 32'(wrEn), 32'h0);
    checkOutput("t3_gnt_still", 32'(gnt), 32'h4);
    applyStimulus(4'b0000, 32'h0);
    tick();
    rdEn = 1'b1;

    $display("[TB] early drop handoff");
    resetDut();
    applyStimulus(4'b0010, 32'hE100D100);
    tick();
    checkOutput("t4_gnt1", 32'(gnt), 32'h2);
    applyStimulus(4'b1010, 32'hE100D100);
    for (int b = 0; b < 2; b++) begin
      checkOutput("t4_wren1", 32'(wrEn), 32'h1);
      checkOutput("t4_data1", 32'(wrData), 32'hD1);
      tick();
    end
    applyStimulus(4'b1000, 32'hE100D100);
    checkOutput("t4_drop_wren", 32'(wrEn), 32'h0);
    tick();
    checkOutput("t4_gnt3", 32'(gnt), 32'h8);
    applyStimulus(4'b1001, 32'hE100D1F0);
    for (int b = 0; b < 4; b++) begin
      checkOutput("t4_gnt3_hold", 32'(gnt), 32'h8);
      checkOutput("t4_wren3", 32'(wrEn), 32'h1);
      checkOutput("t4_data3", 32'(wrData), 32'hE1);
      tick();
    end
    checkOutput("t4_gnt0", 32'(gnt), 32'h1);
    checkOutput("t4_data0", 32'(wrData), 32'hF0);
    applyStimulus(4'b0000, 32'h0);
    tick();

    $display("[TB] reset mid burst");
    resetDut();
    logBase = wrLog.size();
    applyStimulus(4'b0001, 32'h0000F2F1);
    tick();
    checkOutput("t5_gnt", 32'(gnt), 32'h1);
    for (int b = 0; b < 2; b++) begin
      checkOutput("t5_wren", 32'(wrEn), 32'h1);
      tick();
    end
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_wren", 32'(wrEn), 32'h0);
    tick();
    checkOutput("t5_rst_gnt", 32'(gnt), 32'h0);
    checkOutput("t5_log_len", 32'(wrLog.size() - logBase), 32'd2);
    rst = 1'b0;
    applyStimulus(4'b0011, 32'h0000F2F1);
    checkOutput("t5_idle_wren", 32'(wrEn), 32'h0);
    tick();
    checkOutput("t5_first_gnt", 32'(gnt), 32'h1);
    checkOutput("t5_first_data", 32'(wrData), 32'hF1);
    applyStimulus(4'b0000, 32'h0);
    tick();

`ifdef WR_ARB_STATS_EN
    $display("[TB] stall statistics");
    resetDut();
    checkOutput("t6_stall_rst", 32'(stallCnt), 32'h0);
    rdEn = 1'b0;
    fillFifo = 1'b1;
    tick();
    fillFifo = 1'b0;
    applyStimulus(4'b0001, 32'h0);
    tick();
    repeat (10) tick();
    checkOutput("t6_stall_10", 32'(stallCnt), 32'd10);
    repeat (70000) tick();
    checkOutput("t6_stall_sat", 32'(stallCnt), 32'hFFFF);
    applyStimulus(4'b0000, 32'h0);
    resetDut();
    #1;
    checkOutput("t6_stall_clear", 32'(stallCnt), 32'h0);
    rdEn = 1'b1;
`endif

    checkOutput("no_write_when_full", 32'(writeWhileFull), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter N, default 4: number of requesters sharing the syncfifo write port; N>=2.
REQ-002 Parameter WIDTH, default 8: data width, equal to the syncfifo WIDTH.
REQ-003 Parameter MAX_BURST, default 4: maximum number of accepted beats per grant tenure; MAX_BURST>=1.
REQ-004 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_i  input  1  reset, synchronous and active-high.
REQ-006 req_i  input  N  per-requester write request; bit k is requester k.
REQ-007 data_i  input  N*WIDTH  per-requester write data; slice [k*WIDTH +: WIDTH] belongs to requester k.
REQ-008 gnt_o  output  N  registered one-hot or zero grant vector.
REQ-009 fifo_full_i  input  1  syncfifo full_o.
REQ-010 fifo_wr_en_o  output  1  drives syncfifo wr_en.
REQ-011 fifo_wr_data_o  output  WIDTH  drives syncfifo wr_data_i.
REQ-012 stall_cnt_o  output  16  stall statistics; present only with WR_ARB_STATS_EN (REQ-030).

Function
REQ-013 FSM states: IDLE (gnt_o=0) and OWN (exactly one gnt_o bit set).
REQ-014 Accept: a beat from requester k is accepted in any cycle with gnt_o[k] & req_i[k] & ~fifo_full_i.
REQ-015 fifo_wr_en_o shall be combinational and high exactly in accept cycles; fifo_wr_data_o shall equal the owner's data_i slice, and shall be 0 in IDLE.
REQ-016 Grant latency: a request first seen in IDLE shall be granted on the next rising edge, so gnt_o is visible one cycle after req_i; no beat is accepted in the request cycle.
REQ-017 Selection: the new owner is the first requesting index searched upward from rr_ptr, wrapping N-1 to 0.
REQ-018 rr_ptr shall be set to (owner+1) mod N whenever a grant is issued, with wrap N-1 -> 0.
REQ-019 Burst counter: 0 to MAX_BURST, cleared on every grant, incremented only on accept cycles.
REQ-020 Release: OWN ends at the edge where the owner's req_i is low, or where an accept makes the counter reach MAX_BURST.
REQ-021 Handoff: on release, if any other request is pending, the next owner per REQ-017 shall be granted at the same edge, with no idle cycle; otherwise the FSM goes to IDLE.
REQ-022 If the releasing owner is the only requester after a MAX_BURST release, it shall be re-granted immediately (OWN->OWN) with the counter cleared.
REQ-023 Full: while fifo_full_i=1, fifo_wr_en_o=0, the grant is held, and the counter is frozen; the block shall never write when full, so syncfifo error_o shall never assert from a write.
REQ-024 The block shall not drive or observe the syncfifo read side; simultaneous reads that clear full take effect through fifo_full_i in the same cycle.

Reset
REQ-025 While rst_i=1 at a rising edge: state=IDLE, gnt_o=0, rr_ptr=0, counter=0, stall_cnt_o=0.
REQ-026 During reset cycles, fifo_wr_en_o=0 regardless of req_i.
REQ-027 Reset mid-tenure shall abort the grant; any beat not accepted before the reset edge is not written.
REQ-028 After deassertion, the first grant follows REQ-016 with rr_ptr=0, so requester 0 wins any tie.

Configuration
REQ-029 Macro WR_ARB_STATS_EN controls the statistics feature.
REQ-030 Defined: the stall_cnt_o port exists; it increments by 1 in each cycle with an owner request and fifo_full_i=1, saturates at 16'hFFFF, and is cleared only by reset.
REQ-031 Undefined: the stall_cnt_o port and its logic shall be absent; all other behaviour is identical.

Verification
REQ-032 Single requester: req_i=4'b0001, data 8'hA1..8'hA6, FIFO never full -> gnt_o=0001 one cycle after req; 4 accepts, then re-grant per REQ-022 and 2 more accepts; FIFO holds A1..A6 in order.
REQ-033 All requesters: req_i=4'b1111 held -> owners 0,1,2,3,0 in turn, each with exactly 4 writes, handoffs without bubbles, and fifo_wr_en_o high every cycle after the first grant.
REQ-034 Full stall: fill the FIFO to 16 entries, then requester 2 requests -> gnt_o=0100 held, fifo_wr_en_o=0, and no error_o; one syncfifo read -> exactly one accept in the following cycle.
REQ-035 Early drop: requester 1 drops req_i after 2 accepts while requester 3 is waiting -> gnt_o moves to 1000 at the next edge and requester 3's counter starts at 0.
REQ-036 Reset mid-burst: rst_i=1 for 1 cycle after 2 accepts by requester 0 -> gnt_o=0, fifo_wr_en_o=0 in the reset cycle; after release with req_i=4'b0011, requester 0 is granted first.
REQ-037 Statistics with WR_ARB_STATS_EN: full FIFO with owner requesting for 10 cycles -> stall_cnt_o=10; forced 70000 stall cycles -> stall_cnt_o=16'hFFFF.
